// File: rtl/trace_pkg.sv
// Shared types and entry layout for the bus trace buffer.
// Entry layout, MSB to LSB: {ts, pc, instr, addr, wdata, rdata, we}.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_ALL     = 2'd0,
    MODE_PC      = 2'd1,
    MODE_STORE   = 2'd2,
    MODE_ALL_ALT = 2'd3
  } mode_t;

  localparam int INSTR_W = 32;
  localparam int WE_W    = 1;

  // Field offsets depend on the address width, so they are constant functions.
  function automatic int entry_w(input int xlen, input int ts_w);
    return ts_w + 4 * xlen + INSTR_W + WE_W;
  endfunction

  function automatic int off_we();
    return 0;
  endfunction

  function automatic int off_rdata();
    return WE_W;
  endfunction

  function automatic int off_wdata(input int xlen);
    return WE_W + xlen;
  endfunction

  function automatic int off_addr(input int xlen);
    return WE_W + 2 * xlen;
  endfunction

  function automatic int off_instr(input int xlen);
    return WE_W + 3 * xlen;
  endfunction

  function automatic int off_pc(input int xlen);
    return WE_W + 3 * xlen + INSTR_W;
  endfunction

  function automatic int off_ts(input int xlen);
    return WE_W + 4 * xlen + INSTR_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: single write port, single registered read port, no reset.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 177
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on request; registered read only when a readout is requested.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// Bus trace buffer: qualified sampling of PC/instruction/bus activity into a
// circular buffer, address trigger with post-trigger capture, indexed readout.
module bus_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int TS_W  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [XLEN-1:0]                     mon_pc,
  input  logic [31:0]                         mon_instr,
  input  logic [XLEN-1:0]                     bus_addr,
  input  logic [XLEN-1:0]                     bus_wdata,
  input  logic [XLEN-1:0]                     bus_rdata,
  input  logic                                bus_we,
  input  logic                                arm,
  input  logic [1:0]                          mode,
  input  logic [XLEN-1:0]                     trig_addr,
  input  logic [XLEN-1:0]                     trig_mask,
  input  logic [$clog2(DEPTH)-1:0]            post_cnt,
  input  logic                                rd_en,
  input  logic [$clog2(DEPTH)-1:0]            rd_idx,
  output logic                                rd_valid,
  output logic [TS_W+4*XLEN+33-1:0]           rd_entry,
  output logic [1:0]                          state_o,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic                                wrapped,
  output logic                                done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(XLEN, TS_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          state;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   pcnt;
  logic [AW:0]     count;
  logic            wrapped_q;
  logic [TS_W-1:0] ts;
  logic [XLEN-1:0] prev_pc;
  logic            first;

  logic            capturing;
  logic            qual;
  logic            trig;
  logic            wr;
  logic [EW-1:0]   wr_entry;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_vld_p1;
  logic            rd_zero_p1;
  logic [EW-1:0]   ram_q_p1;

  // Sample qualifier, trigger compare and write decision for the current cycle.
  always_comb begin
    capturing = (state == ST_ARMED) || (state == ST_POST);
    qual      = 1'b1;
    case (mode_t'(mode))
      MODE_PC:    qual = first || (mon_pc != prev_pc);
      MODE_STORE: qual = bus_we;
      default:    qual = 1'b1;
    endcase
    trig     = (state == ST_ARMED) && (((bus_addr ^ trig_addr) & trig_mask) == '0);
    wr       = !arm && capturing && (qual || trig);
    wr_entry = {ts, mon_pc, mon_instr, bus_addr, bus_wdata, bus_rdata, bus_we};
    rd_req   = rd_en && (state == ST_DONE) && !arm;
    rd_addr  = (wrapped_q ? wp : '0) + rd_idx;
  end

  // Capture FSM with write pointer, fill count, timestamp and post counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wp        <= '0;
      pcnt      <= '0;
      count     <= '0;
      wrapped_q <= 1'b0;
      ts        <= '0;
      first     <= 1'b0;
    end else if (arm) begin
      state     <= ST_ARMED;
      wp        <= '0;
      count     <= '0;
      wrapped_q <= 1'b0;
      ts        <= '0;
      first     <= 1'b1;
    end else begin
      if (capturing) begin
        ts    <= ts + 1'b1;
        first <= 1'b0;
      end
      if (wr) begin
        wp <= wp + 1'b1;
        if (count == FULL) begin
          wrapped_q <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      case (state)
        ST_ARMED: begin
          if (trig) begin
            pcnt  <= post_cnt;
            state <= (post_cnt == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (wr) begin
            pcnt <= pcnt - 1'b1;
            if (pcnt == AW'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Previous-cycle PC for the change-of-flow qualifier.
  always_ff @(posedge clk) begin
    prev_pc <= mon_pc;
  end

  // Readout stage p1: valid and out-of-range flag aligned with the RAM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1  <= 1'b0;
      rd_zero_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_req;
      rd_zero_p1 <= ({1'b0, rd_idx} >= count);
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wp),
    .wdata (wr_entry),
    .re    (rd_req),
    .raddr (rd_addr),
    .rdata (ram_q_p1)
  );

  assign rd_valid = rd_vld_p1;
  assign rd_entry = (rd_vld_p1 && !rd_zero_p1) ? ram_q_p1 : '0;
  assign state_o  = state;
  assign count_o  = count;
  assign wrapped  = wrapped_q;
  assign done     = (state == ST_DONE);

endmodule
